// File: rtl/muldiv_unit_pkg.sv
// Shared types and operation codes for the iterative RV32M multiply/divide unit.
// Function codes mirror the ALU_MUL..ALU_REMU encodings driven by alu_control.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MULDIV_IDLE,
        MULDIV_CALC,
        MULDIV_FIX,
        MULDIV_DONE
    } muldiv_state_e;

    // Low three bits of an M-extension alu_function select the operation.
    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } md_op_e;

    localparam logic [4:0] ALU_MUL    = 5'b10000;
    localparam logic [4:0] ALU_MULH   = 5'b10001;
    localparam logic [4:0] ALU_MULHSU = 5'b10010;
    localparam logic [4:0] ALU_MULHU  = 5'b10011;
    localparam logic [4:0] ALU_DIV    = 5'b10100;
    localparam logic [4:0] ALU_DIVU   = 5'b10101;
    localparam logic [4:0] ALU_REM    = 5'b10110;
    localparam logic [4:0] ALU_REMU   = 5'b10111;

    function automatic logic is_m_op(input logic [4:0] func);
        return func[4:3] == 2'b10;
    endfunction

    function automatic int muldiv_cycles(input int xlen);
        return xlen + 2;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide sharing
// one shift register and counter; divide-by-zero and overflow resolve in one cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      alu_function,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic signed [XLEN-1:0] S_MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    muldiv_state_e     state_q, state_d;
    md_op_e            op_q, op_in;
    logic              sign_a_q, sign_b_q;
    logic [XLEN-1:0]   addend_q;
    logic [2*XLEN:0]   sreg_q;
    logic [CNT_W-1:0]  count_q;

    logic              accept, fast, is_mul_in, a_signed_in, b_signed_in;
    logic              sign_a_in, sign_b_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in, fast_result, fix_result;
    logic signed [XLEN-1:0] a_s;

    // Operand decode for the request presented this cycle
    assign op_in       = md_op_e'(alu_function[2:0]);
    assign is_mul_in   = ~alu_function[2];
    assign a_signed_in = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_signed_in = op_in inside {OP_MULH, OP_DIV, OP_REM};
    assign sign_a_in   = a_signed_in & operand_a[XLEN-1];
    assign sign_b_in   = b_signed_in & operand_b[XLEN-1];
    assign mag_a_in    = cond_neg(operand_a, sign_a_in);
    assign mag_b_in    = cond_neg(operand_b, sign_b_in);
    assign a_s         = operand_a;

    assign accept = start && !flush && (state_q == MULDIV_IDLE || state_q == MULDIV_DONE);
    assign busy   = (state_q == MULDIV_CALC) || (state_q == MULDIV_FIX);
    assign done   = (state_q == MULDIV_DONE);

    always_comb begin
        fast        = 1'b0;
        fast_result = '0;
        if (!is_m_op(alu_function)) begin
            fast = 1'b1;
        end else begin
            unique case (op_in)
                OP_DIV, OP_DIVU: begin
                    if (operand_b == '0) begin
                        fast        = 1'b1;
                        fast_result = '1;
                    end else if (op_in == OP_DIV && a_s == S_MIN && operand_b == '1) begin
                        fast        = 1'b1;
                        fast_result = operand_a;
                    end
                end
                OP_REM, OP_REMU: begin
                    if (operand_b == '0) begin
                        fast        = 1'b1;
                        fast_result = operand_a;
                    end else if (op_in == OP_REM && a_s == S_MIN && operand_b == '1) begin
                        fast        = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // One iteration step: multiply adds into the upper half and shifts right,
    // divide shifts left and subtracts the divisor when it fits.
    logic [XLEN:0]   mul_sum, div_part, div_diff;
    logic            div_ge;
    logic [2*XLEN:0] mul_next, div_next;

    assign mul_sum  = sreg_q[2*XLEN:XLEN] + (sreg_q[0] ? {1'b0, addend_q} : '0);
    assign mul_next = {1'b0, mul_sum, sreg_q[XLEN-1:1]};
    assign div_part = sreg_q[2*XLEN-1:XLEN-1];
    assign div_ge   = div_part >= {1'b0, addend_q};
    assign div_diff = div_part - {1'b0, addend_q};
    assign div_next = {(div_ge ? div_diff : div_part), sreg_q[XLEN-2:0], div_ge};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    assign prod = cond_neg_wide(sreg_q[2*XLEN-1:0], sign_a_q ^ sign_b_q);
    assign quot = cond_neg(sreg_q[XLEN-1:0], sign_a_q ^ sign_b_q);
    assign rem  = cond_neg(sreg_q[2*XLEN-1:XLEN], sign_a_q);

    always_comb begin
        fix_result = '0;
        unique case (op_q)
            OP_MUL:                       fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quot;
            OP_REM, OP_REMU:              fix_result = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MULDIV_IDLE, MULDIV_DONE: begin
                if (accept) state_d = fast ? MULDIV_DONE : MULDIV_CALC;
                else        state_d = MULDIV_IDLE;
            end
            MULDIV_CALC: if (count_q == '0) state_d = MULDIV_FIX;
            MULDIV_FIX:  state_d = MULDIV_DONE;
        endcase
        if (flush) state_d = MULDIV_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= MULDIV_IDLE;
            count_q <= '0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                count_q <= CNT_LAST;
            else if (state_q == MULDIV_CALC && count_q != '0)
                count_q <= count_q - 1'b1;
            if (state_q == MULDIV_FIX && !flush)
                result <= fix_result;
            else if (accept && fast)
                result <= fast_result;
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_q     <= op_in;
            sign_a_q <= sign_a_in;
            sign_b_q <= sign_b_in;
            addend_q <= is_mul_in ? mag_a_in : mag_b_in;
            sreg_q   <= {{(XLEN+1){1'b0}}, (is_mul_in ? mag_b_in : mag_a_in)};
        end else if (state_q == MULDIV_CALC) begin
            sreg_q   <= op_q[2] ? div_next : mul_next;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: scoreboard of expected results, latency and busy checks.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  alu_function = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .flush(flush),
        .alu_function(alu_function), .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit expect_out);
        start = 1'b1; alu_function = f; operand_a = a; operand_b = b;
        if (expect_out) sb.push_back(exp);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle, so a back-to-back issue may follow.
    task automatic wait_done(input string tag, input int lat, input int busy_len, input int poke_at);
        int n = 0;
        int bcnt = 0;
        bit seen = 0;
        logic [31:0] e;
        while (!seen && n < 60) begin
            @(negedge clock);
            n++;
            if (busy) bcnt++;
            if (done) seen = 1;
            if (n == poke_at) begin
                start = 1'b1; alu_function = ALU_DIVU; operand_a = 32'd9; operand_b = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, " latency"}, seen ? n : -1, lat);
        check({tag, " busy cycles"}, bcnt, busy_len);
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check({tag, " result"}, result, e);
    endtask

    initial begin
        int dcnt;
        repeat (3) @(negedge clock);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Normal ops, each one started back-to-back in the previous done cycle
        issue(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
        wait_done("MUL", 34, 33, 0);
        issue(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        wait_done("MULH", 34, 33, 0);
        issue(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        wait_done("MULHU", 34, 33, 0);
        issue(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_done("MULHSU", 34, 33, 0);
        issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1);
        wait_done("DIV", 34, 33, 0);
        issue(ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1);
        wait_done("REM", 34, 33, 0);
        issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, 1);
        wait_done("DIVU", 34, 33, 0);
        issue(ALU_REMU, 32'd100, 32'd7, 32'd2, 1);
        wait_done("REMU", 34, 33, 0);

        // Fast path, also chained back-to-back
        issue(ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        wait_done("DIVU by zero", 1, 0, 0);
        issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        wait_done("DIV overflow", 1, 0, 0);
        issue(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        wait_done("REM overflow", 1, 0, 0);
        issue(5'b00011, 32'd12, 32'd34, 32'h0, 1);
        wait_done("non-M op", 1, 0, 0);
        issue(ALU_REM, 32'd5, 32'd0, 32'd5, 1);
        wait_done("REM by zero", 1, 0, 0);

        @(negedge clock);
        check("done pulse ends", done, 0);

        // Flush mid-multiply
        issue(ALU_MUL, 32'd3, 32'd4, 32'd0, 0);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        check("flush busy", busy, 0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        check("flush no done", dcnt, 0);
        check("flush result held", result, 32'd5);

        // Reset mid-multiply
        issue(ALU_MUL, 32'd3, 32'd4, 32'd0, 0);
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("abort reset result", result, 0);
        check("abort reset busy", busy, 0);
        check("abort reset done", done, 0);

        // start pulsed during a running divide must be ignored
        issue(ALU_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1);
        wait_done("DIV ignore start", 34, 33, 5);

        @(negedge clock);
        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
